// File: rtl/trigger_qualifier.sv
// ============================================================================
// Module   : trigger_qualifier
// Brief    : Selects which synchronized edge pulses are forwarded to the
//            delay stage, using arm/disarm control, a PASS / SINGLE / COUNT
//            mode and a post-fire holdoff window. Keeps saturating counts
//            of forwarded and rejected edges.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trigger_qualifier #(
   parameter int CNT_BITS     = 16,
   parameter int HOLDOFF_BITS = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    edge_pulse_in,
   input  logic                    arm,
   input  logic                    disarm,
   input  logic                    cfg_update,
   input  logic [1:0]              cfg_mode,
   input  logic [CNT_BITS-1:0]     cfg_skip,
   input  logic [HOLDOFF_BITS-1:0] cfg_holdoff,
   input  logic                    clear_stats,
   output logic                    trig_out,
   output logic                    armed,
   output logic                    done,
   output logic [CNT_BITS-1:0]     fired_count,
   output logic [CNT_BITS-1:0]     dropped_count
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_HOLDOFF = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam logic [1:0] C_MODE_PASS   = 2'b00;
   localparam logic [1:0] C_MODE_SINGLE = 2'b01;
   localparam logic [1:0] C_MODE_COUNT  = 2'b10;

   localparam logic [CNT_BITS-1:0]     C_CNT_MAX  = {CNT_BITS{1'b1}};
   localparam logic [CNT_BITS-1:0]     C_CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
   localparam logic [HOLDOFF_BITS-1:0] C_HOLD_ONE = {{(HOLDOFF_BITS-1){1'b0}}, 1'b1};

   state_t                  state_q, state_d;
   logic [1:0]              mode_q;
   logic [CNT_BITS-1:0]     skip_q;
   logic [HOLDOFF_BITS-1:0] holdoff_q;
   logic [CNT_BITS-1:0]     skip_cnt_q, skip_cnt_d;
   logic [HOLDOFF_BITS-1:0] hold_cnt_q, hold_cnt_d;
   logic                    fire_d;
   logic                    drop_d;
   logic                    trig_q;
   logic                    armed_q;
   logic                    done_q;
   logic [CNT_BITS-1:0]     fired_q;
   logic [CNT_BITS-1:0]     dropped_q;

   // Next state and per-cycle fire/drop decision, in control priority order.
   always_comb begin
      state_d    = state_q;
      skip_cnt_d = skip_cnt_q;
      hold_cnt_d = hold_cnt_q;
      fire_d     = 1'b0;
      drop_d     = 1'b0;

      if (cfg_update) begin
         state_d    = S_IDLE;
         skip_cnt_d = '0;
         hold_cnt_d = '0;
         drop_d     = edge_pulse_in;
      end else if (disarm) begin
         state_d = S_IDLE;
         drop_d  = edge_pulse_in;
      end else if (arm && (state_q == S_IDLE || state_q == S_DONE)) begin
         // Arm from IDLE/DONE restarts the skip count; the edge is lost.
         state_d    = S_ARMED;
         skip_cnt_d = '0;
         drop_d     = edge_pulse_in;
      end else begin
         case (state_q)
            S_ARMED: begin
               if (edge_pulse_in) begin
                  case (cfg_mode_eff(mode_q))
                     C_MODE_SINGLE: begin
                        fire_d  = 1'b1;
                        state_d = S_DONE;
                     end
                     C_MODE_COUNT: begin
                        if (skip_cnt_q == skip_q) begin
                           fire_d  = 1'b1;
                           state_d = S_DONE;
                        end else begin
                           drop_d     = 1'b1;
                           skip_cnt_d = skip_cnt_q + C_CNT_ONE;
                        end
                     end
                     default: begin
                        fire_d = 1'b1;
                        if (holdoff_q != '0) begin
                           hold_cnt_d = holdoff_q;
                           state_d    = S_HOLDOFF;
                        end
                     end
                  endcase
               end
            end
            S_HOLDOFF: begin
               // Arm is ignored here; the window always runs to completion.
               drop_d     = edge_pulse_in;
               hold_cnt_d = hold_cnt_q - C_HOLD_ONE;
               if (hold_cnt_q <= C_HOLD_ONE) begin
                  hold_cnt_d = '0;
                  state_d    = S_ARMED;
               end
            end
            default: begin
               drop_d = edge_pulse_in;
            end
         endcase
      end
   end

   // Mode 11 is an unused encoding and behaves as PASS.
   function automatic logic [1:0] cfg_mode_eff(input logic [1:0] m);
      return (m == 2'b11) ? C_MODE_PASS : m;
   endfunction

   // State, shadow configuration and internal counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         mode_q     <= C_MODE_PASS;
         skip_q     <= '0;
         holdoff_q  <= '0;
         skip_cnt_q <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         skip_cnt_q <= skip_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         if (cfg_update) begin
            mode_q    <= cfg_mode;
            skip_q    <= cfg_skip;
            holdoff_q <= cfg_holdoff;
         end
      end
   end

   // Registered outputs and saturating statistics; clear beats increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_q    <= 1'b0;
         armed_q   <= 1'b0;
         done_q    <= 1'b0;
         fired_q   <= '0;
         dropped_q <= '0;
      end else begin
         trig_q  <= fire_d;
         armed_q <= (state_d == S_ARMED) || (state_d == S_HOLDOFF);
         done_q  <= (state_d == S_DONE);
         if (clear_stats) begin
            fired_q   <= '0;
            dropped_q <= '0;
         end else begin
            if (fire_d && fired_q != C_CNT_MAX) begin
               fired_q <= fired_q + C_CNT_ONE;
            end
            if (drop_d && dropped_q != C_CNT_MAX) begin
               dropped_q <= dropped_q + C_CNT_ONE;
            end
         end
      end
   end

   assign trig_out      = trig_q;
   assign armed         = armed_q;
   assign done          = done_q;
   assign fired_count   = fired_q;
   assign dropped_count = dropped_q;

endmodule

`default_nettype wire

// File: tb/tb_trigger_qualifier.sv
// ============================================================================
// Module   : tb_trigger_qualifier
// Brief    : Directed-vector bench for trigger_qualifier with hand-computed
//            expected values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trigger_qualifier;

   localparam int CNT_BITS     = 16;
   localparam int HOLDOFF_BITS = 32;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    edge_pulse_in = 1'b0;
   logic                    arm = 1'b0;
   logic                    disarm = 1'b0;
   logic                    cfg_update = 1'b0;
   logic [1:0]              cfg_mode = 2'b00;
   logic [CNT_BITS-1:0]     cfg_skip = '0;
   logic [HOLDOFF_BITS-1:0] cfg_holdoff = '0;
   logic                    clear_stats = 1'b0;
   logic                    trig_out;
   logic                    armed;
   logic                    done;
   logic [CNT_BITS-1:0]     fired_count;
   logic [CNT_BITS-1:0]     dropped_count;

   int vectors     = 0;
   int miscompares = 0;

   trigger_qualifier #(
      .CNT_BITS    (CNT_BITS),
      .HOLDOFF_BITS(HOLDOFF_BITS)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .edge_pulse_in(edge_pulse_in),
      .arm          (arm),
      .disarm       (disarm),
      .cfg_update   (cfg_update),
      .cfg_mode     (cfg_mode),
      .cfg_skip     (cfg_skip),
      .cfg_holdoff  (cfg_holdoff),
      .clear_stats  (clear_stats),
      .trig_out     (trig_out),
      .armed        (armed),
      .done         (done),
      .fired_count  (fired_count),
      .dropped_count(dropped_count)
   );

   // 200 MHz system clock.
   always #2.5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock cycle with the given pulses applied; returns 1 ns after the edge.
   task automatic step(input logic e = 1'b0, input logic a = 1'b0, input logic d = 1'b0,
                       input logic u = 1'b0, input logic c = 1'b0);
      edge_pulse_in = e;
      arm           = a;
      disarm        = d;
      cfg_update    = u;
      clear_stats   = c;
      @(posedge clk);
      #1;
      edge_pulse_in = 1'b0;
      arm           = 1'b0;
      disarm        = 1'b0;
      cfg_update    = 1'b0;
      clear_stats   = 1'b0;
   endtask

   task automatic configure(input logic [1:0] m, input logic [CNT_BITS-1:0] s,
                            input logic [HOLDOFF_BITS-1:0] h);
      cfg_mode    = m;
      cfg_skip    = s;
      cfg_holdoff = h;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      #1;
      check("rst_trig", {31'd0, trig_out}, 32'd0);
      check("rst_armed", {31'd0, armed}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_fired", {16'd0, fired_count}, 32'd0);
      check("rst_dropped", {16'd0, dropped_count}, 32'd0);
      rst_n = 1'b1;
      step();

      // ---------------- PASS, holdoff 0, spaced edges ----------------
      configure(2'b00, 16'd0, 32'd0);
      step(1'b0, 1'b1);
      check("t1_armed", {31'd0, armed}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         check("t1_trig_hi", {31'd0, trig_out}, 32'd1);
         step();
         check("t1_trig_lo", {31'd0, trig_out}, 32'd0);
         repeat (3) step();
      end
      check("t1_fired", {16'd0, fired_count}, 32'd3);
      check("t1_dropped", {16'd0, dropped_count}, 32'd0);
      // back-to-back edges keep trig_out high
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         check("t1_b2b_trig", {31'd0, trig_out}, 32'd1);
      end
      check("t1_b2b_fired", {16'd0, fired_count}, 32'd6);

      // ---------------- edges in IDLE and with arm ----------------
      step(1'b0, 1'b0, 1'b1);
      check("t2_disarmed", {31'd0, armed}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1);
      check("t2_idle_trig", {31'd0, trig_out}, 32'd0);
      step(1'b1, 1'b1);
      check("t2_arm_trig", {31'd0, trig_out}, 32'd0);
      check("t2_armed", {31'd0, armed}, 32'd1);
      check("t2_dropped", {16'd0, dropped_count}, 32'd2);
      check("t2_fired", {16'd0, fired_count}, 32'd0);

      // ---------------- PASS, holdoff 10 ----------------
      configure(2'b00, 16'd0, 32'd10);
      step(1'b0, 1'b1);
      step(1'b1);                                  // T
      check("t3_fire_T", {31'd0, trig_out}, 32'd1);
      repeat (9) step();                           // T+1 .. T+9
      check("t3_hold_armed", {31'd0, armed}, 32'd1);
      step(1'b1);                                  // T+10
      check("t3_block_T10", {31'd0, trig_out}, 32'd0);
      step(1'b1);                                  // T+11
      check("t3_fire_T11", {31'd0, trig_out}, 32'd1);
      check("t3_fired", {16'd0, fired_count}, 32'd2);
      check("t3_dropped", {16'd0, dropped_count}, 32'd1);

      // ---------------- COUNT, skip 3 ----------------
      configure(2'b10, 16'd3, 32'd0);
      step(1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         step(1'b1);
         check("t4_trig", {31'd0, trig_out}, (i == 3) ? 32'd1 : 32'd0);
         step();
      end
      check("t4_done", {31'd0, done}, 32'd1);
      check("t4_armed", {31'd0, armed}, 32'd0);
      check("t4_dropped", {16'd0, dropped_count}, 32'd5);
      step(1'b0, 1'b1);
      check("t4_rearm_done", {31'd0, done}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1);
         check("t4_rearm_trig", {31'd0, trig_out}, (i == 3) ? 32'd1 : 32'd0);
      end
      check("t4_fired", {16'd0, fired_count}, 32'd2);
      check("t4_dropped2", {16'd0, dropped_count}, 32'd8);

      // ---------------- SINGLE, disarm vs edge, cfg_update in HOLDOFF ----------------
      configure(2'b01, 16'd0, 32'd0);
      step(1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      check("t5_disarm_trig", {31'd0, trig_out}, 32'd0);
      check("t5_disarm_armed", {31'd0, armed}, 32'd0);
      check("t5_dropped", {16'd0, dropped_count}, 32'd1);
      step(1'b0, 1'b1);
      step(1'b1);
      check("t5_single_trig", {31'd0, trig_out}, 32'd1);
      step(1'b1);
      check("t5_single_once", {31'd0, trig_out}, 32'd0);
      check("t5_single_done", {31'd0, done}, 32'd1);
      configure(2'b00, 16'd0, 32'd20);
      step(1'b0, 1'b1);
      step(1'b1);
      step();
      check("t5_hold_armed", {31'd0, armed}, 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("t5_cfg_armed", {31'd0, armed}, 32'd0);
      check("t5_cfg_done", {31'd0, done}, 32'd0);

      // ---------------- saturation and clear ----------------
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (65535) step(1'b1);
      check("t6_sat_reach", {16'd0, dropped_count}, 32'h0000FFFF);
      step(1'b1);
      check("t6_sat_hold", {16'd0, dropped_count}, 32'h0000FFFF);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t6_clear_wins", {16'd0, dropped_count}, 32'd0);

      // ---------------- reset mid-HOLDOFF ----------------
      step(1'b0, 1'b1);
      step(1'b1);
      step();
      step();
      check("t6_pre_rst_armed", {31'd0, armed}, 32'd1);
      check("t6_pre_rst_fired", {16'd0, fired_count}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_armed", {31'd0, armed}, 32'd0);
      check("t6_rst_fired", {16'd0, fired_count}, 32'd0);
      check("t6_rst_dropped", {16'd0, dropped_count}, 32'd0);
      check("t6_rst_trig", {31'd0, trig_out}, 32'd0);
      check("t6_rst_done", {31'd0, done}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
